// File: rtl/puf_race_sequencer.sv
// puf_race_sequencer: steps the asynchronous race arbiter through RESP_BITS
// races (settle, launch, wait for done, sample winner) and assembles the
// winners into a response word handed off over a valid/ready handshake.
// A per-race timeout abandons races that never finish.
module puf_race_sequencer #(
  parameter int RESP_BITS      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDX_W         = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic                 arb_reset,
  output logic                 launch,
  output logic [IDX_W-1:0]     bit_idx,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 timeout_err
);

  // One counter serves both the settle phase and the wait phase.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [RESP_BITS-1:0] resp_r, resp_nxt_s;
  logic                 tmo_r, tmo_nxt_s;

  logic done_meta_r, done_sync_r;
  logic out_meta_r, out_sync_r;

  logic arb_reset_r, launch_r, busy_r, valid_r;

  // Two-flop synchronizers for the arbiter's asynchronous done and winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_meta_r <= 1'b0;
      done_sync_r <= 1'b0;
      out_meta_r  <= 1'b0;
      out_sync_r  <= 1'b0;
    end else begin
      done_meta_r <= arb_done;
      done_sync_r <= done_meta_r;
      out_meta_r  <= arb_out;
      out_sync_r  <= out_meta_r;
    end
  end

  // Next-state and datapath update; decisions use only synchronized arbiter signals.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    resp_nxt_s  = resp_r;
    tmo_nxt_s   = tmo_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          resp_nxt_s  = {RESP_BITS{1'b0}};
          tmo_nxt_s   = 1'b0;
          idx_nxt_s   = {IDX_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Counter parks on its last value while a stale done keeps us here.
        if (cnt_r == SETTLE_LAST) begin
          if (!done_sync_r) begin
            state_nxt_s = ST_LAUNCH;
          end else begin
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_LAUNCH: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the final wait cycle still counts as a finished race.
        if (done_sync_r) begin
          resp_nxt_s[idx_r] = out_sync_r;
          state_nxt_s       = ST_NEXT;
        end else if (cnt_r == TMO_LAST) begin
          resp_nxt_s[idx_r] = 1'b0;
          tmo_nxt_s         = 1'b1;
          state_nxt_s       = ST_NEXT;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state
  // so each one is a flop that mirrors the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      resp_r      <= {RESP_BITS{1'b0}};
      tmo_r       <= 1'b0;
      arb_reset_r <= 1'b1;
      launch_r    <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      resp_r      <= resp_nxt_s;
      tmo_r       <= tmo_nxt_s;
      arb_reset_r <= (state_nxt_s != ST_LAUNCH) && (state_nxt_s != ST_WAIT);
      launch_r    <= (state_nxt_s == ST_LAUNCH);
      busy_r      <= (state_nxt_s != ST_IDLE);
      valid_r     <= (state_nxt_s == ST_DONE);
    end
  end

  assign arb_reset   = arb_reset_r;
  assign launch      = launch_r;
  assign bit_idx     = idx_r;
  assign busy        = busy_r;
  assign resp        = resp_r;
  assign resp_valid  = valid_r;
  assign timeout_err = tmo_r;

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Directed bench for puf_race_sequencer with a behavioural arbiter model and a
// scoreboard of expected response words.
module tb_puf_race_sequencer;

  localparam int RB = 8;
  localparam int SC = 4;
  localparam int TC = 16;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       start      = 1'b0;
  logic       arb_done   = 1'b0;
  logic       arb_out    = 1'b0;
  logic       resp_ready = 1'b0;
  logic       arb_reset, launch, busy, resp_valid, timeout_err;
  logic [2:0] bit_idx;
  logic [7:0] resp;

  int n_tests = 0;
  int n_fail  = 0;

  // arbiter model configuration (written by the stimulus, read by the model)
  logic [7:0] pat_cfg   = 8'h00;
  int         dly_cfg   = 2;
  int         never_bit = -1;
  bit         stuck     = 1'b0;
  int         cd        = -1;

  logic [7:0] exp_resp_q[$];
  logic       exp_tmo_q[$];

  puf_race_sequencer #(
    .RESP_BITS(RB), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .arb_done(arb_done), .arb_out(arb_out),
    .arb_reset(arb_reset), .launch(launch), .bit_idx(bit_idx),
    .busy(busy), .resp(resp), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Arbiter model: cleared by arb_reset, answers dly_cfg negedges after launch.
  always @(negedge clk) begin
    if (stuck) begin
      arb_done <= 1'b1;
    end else if (arb_reset) begin
      arb_done <= 1'b0;
      cd       <= -1;
    end else if (launch) begin
      cd <= dly_cfg;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && int'(bit_idx) != never_bit) begin
        arb_done <= 1'b1;
        arb_out  <= pat_cfg[bit_idx];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_arb_reset", arb_reset, 1);
    check("rst_launch", launch, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_resp", resp, 0);
    check("rst_bit_idx", bit_idx, 0);
  endtask

  // One full response: pattern, model delay, bit that never finishes (-1 none),
  // stuck-done cycles (0 none), DONE hold cycles, start pulse during a WAIT.
  task automatic run_resp(input logic [7:0] pat, input int dly, input int nb,
                          input int stuck_cyc, input int hold_cyc, input bit ign_start);
    logic [7:0] exp_r;
    logic       exp_t;
    int         launches, first_l, t, wcnt, widx;
    bit         in_wait;
    int         waits[8];
    exp_r = pat;
    if (nb >= 0) exp_r[nb] = 1'b0;
    exp_resp_q.push_back(exp_r);
    exp_tmo_q.push_back(nb >= 0);
    pat_cfg   = pat;
    dly_cfg   = dly;
    never_bit = nb;
    stuck     = (stuck_cyc > 0);

    start = 1'b1;
    step();
    start = 1'b0;
    t = 1;
    check("busy_rise", busy, 1);
    check("bit_idx_start", bit_idx, 0);

    launches = 0; first_l = -1; in_wait = 1'b0; wcnt = 0; widx = 0;
    for (int k = 0; k < 8; k++) waits[k] = 0;
    while (!resp_valid && t < 3000) begin
      if (launch) begin
        launches++;
        if (first_l < 0) first_l = t;
        check("bit_idx_step", bit_idx, launches - 1);
        in_wait = 1'b1;
        wcnt    = 0;
        widx    = int'(bit_idx);
      end else if (in_wait) begin
        if (!arb_reset) begin
          wcnt++;
        end else begin
          in_wait     = 1'b0;
          waits[widx] = wcnt;
        end
      end else if (stuck_cyc > 0 && launches == 0) begin
        check("stuck_arb_reset", arb_reset, 1);
      end
      if (stuck_cyc > 0 && t == stuck_cyc) stuck = 1'b0;
      if (ign_start && launches == 3 && in_wait && wcnt == 1) start = 1'b1;
      else start = 1'b0;
      step();
      t++;
    end
    start = 1'b0;

    check("resp_valid_seen", resp_valid, 1);
    check("launch_count", launches, 8);
    check("first_launch_cycle", first_l, (stuck_cyc > 0) ? stuck_cyc + 3 : 5);
    if (nb >= 0) check("timeout_wait_len", waits[nb], TC);
    check("race_wait_len", waits[(nb == 0) ? 1 : 0], dly + 2);
    check("done_arb_reset", arb_reset, 1);

    check("sb_nonempty", exp_resp_q.size(), 1);
    if (exp_resp_q.size() > 0) begin
      exp_r = exp_resp_q.pop_front();
      exp_t = exp_tmo_q.pop_front();
      check("resp_word", resp, exp_r);
      check("timeout_err", timeout_err, exp_t);

      for (int k = 0; k < hold_cyc; k++) begin
        start      = (k == 3);
        resp_ready = 1'b0;
        step();
        check("hold_valid", resp_valid, 1);
        check("hold_resp", resp, exp_r);
        check("hold_busy", busy, 1);
      end
      start      = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("idle_valid_low", resp_valid, 0);
      check("idle_busy_low", busy, 0);
      check("idle_resp_kept", resp, exp_r);
      check("idle_tmo_kept", timeout_err, exp_t);
      step();
      check("no_restart", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    check_reset_values();
    reset = 1'b0;
    step();

    // full 8-bit response, done 2 cycles after each launch
    run_resp(8'h4D, 2, -1, 0, 0, 1'b0);
    // bit 3 never finishes
    run_resp(8'hFF, 2, 3, 0, 0, 1'b0);
    // done stuck high through CLEAR of bit 0
    run_resp(8'hA5, 1, -1, 12, 0, 1'b0);
    // back-pressure in DONE and start pulses in WAIT and DONE
    run_resp(8'h3C, 3, -1, 0, 10, 1'b1);

    // reset during WAIT of bit 2 (bit 0 times out first so timeout_err is set)
    pat_cfg = 8'hFF; dly_cfg = 2; never_bit = 0; stuck = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 500 && !(bit_idx == 3'd2 && !arb_reset && !launch); t++) step();
    check("reached_bit2_wait", bit_idx, 2);
    check("tmo_before_reset", timeout_err, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values();
    step();
    run_resp(8'h96, 2, -1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
